// File: rtl/bist_sequencer.sv
// bist_sequencer: logic-BIST loop controller. Sequences INIT, shift/capture
// pattern loops, a final unload into the MISR and a signature compare, and
// reports the result through a START/BIST_END handshake.
// Control outputs are registered decodes of the current state, so every
// output appears one clock after the state it belongs to.
module bist_sequencer #(
  parameter int                CHAIN_LEN  = 8,
  parameter int                N_PATTERNS = 64,
  parameter int                SIG_W      = 3,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG = 3'b101
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              START,
  input  logic [SIG_W-1:0]                  MISR_SIG,
  output logic                              SCAN_EN,
  output logic                              TEST_MODE,
  output logic                              LFSR_EN,
  output logic                              MISR_EN,
  output logic                              MISR_CLR,
  output logic                              BUSY,
  output logic [$clog2(N_PATTERNS+1)-1:0]   PAT_CNT,
  output logic                              BIST_END,
  output logic                              PASS_FAIL
);

  localparam int SC_W = $clog2(CHAIN_LEN + 1);
  localparam int PC_W = $clog2(N_PATTERNS + 1);
  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0] PAT_MAX    = PC_W'(N_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_FLUSH   = 3'd4,
    S_COMPARE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t          state_reg;
  logic [SC_W-1:0] shift_cnt_reg;
  logic [PC_W-1:0] pat_cnt_reg;
  // High during the cycle in which the outputs present COMPARE; by then the
  // MISR has absorbed its final FLUSH update.
  logic            cmp_reg;

  assign PAT_CNT = pat_cnt_reg;

  // Sequencer state, counters, registered control decodes and result flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= S_IDLE;
      shift_cnt_reg <= '0;
      pat_cnt_reg   <= '0;
      cmp_reg       <= 1'b0;
      SCAN_EN       <= 1'b0;
      TEST_MODE     <= 1'b0;
      LFSR_EN       <= 1'b0;
      MISR_EN       <= 1'b0;
      MISR_CLR      <= 1'b0;
      BUSY          <= 1'b0;
      BIST_END      <= 1'b0;
      PASS_FAIL     <= 1'b0;
    end else begin
      SCAN_EN   <= (state_reg == S_SHIFT) || (state_reg == S_FLUSH);
      LFSR_EN   <= (state_reg == S_SHIFT) || (state_reg == S_CAPTURE);
      MISR_EN   <= (state_reg == S_SHIFT) || (state_reg == S_CAPTURE) ||
                   (state_reg == S_FLUSH);
      MISR_CLR  <= (state_reg == S_INIT);
      TEST_MODE <= (state_reg != S_IDLE) && (state_reg != S_DONE);
      BUSY      <= (state_reg != S_IDLE) && (state_reg != S_DONE);
      cmp_reg   <= (state_reg == S_COMPARE);

      if (cmp_reg) begin
        PASS_FAIL <= (MISR_SIG == GOLDEN_SIG);
      end
      if (state_reg == S_DONE) begin
        BIST_END <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (START) begin
            state_reg <= S_INIT;
            BIST_END  <= 1'b0;
            PASS_FAIL <= 1'b0;
          end
        end
        S_INIT: begin
          pat_cnt_reg   <= '0;
          shift_cnt_reg <= '0;
          state_reg     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (shift_cnt_reg == SHIFT_LAST) begin
            shift_cnt_reg <= '0;
            state_reg     <= S_CAPTURE;
          end else begin
            shift_cnt_reg <= shift_cnt_reg + 1'b1;
          end
        end
        S_CAPTURE: begin
          shift_cnt_reg <= '0;
          if (pat_cnt_reg != PAT_MAX) begin
            pat_cnt_reg <= pat_cnt_reg + 1'b1;
          end
          if (pat_cnt_reg + 1'b1 == PAT_MAX) begin
            state_reg <= S_FLUSH;
          end else begin
            state_reg <= S_SHIFT;
          end
        end
        S_FLUSH: begin
          if (shift_cnt_reg == SHIFT_LAST) begin
            shift_cnt_reg <= '0;
            state_reg     <= S_COMPARE;
          end else begin
            shift_cnt_reg <= shift_cnt_reg + 1'b1;
          end
        end
        S_COMPARE: begin
          state_reg <= S_DONE;
        end
        S_DONE: begin
          if (!START) begin
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
